// File: rtl/mem_arbiter_llsc.sv
// Round-robin arbiter from N CPU memory ports onto one RAM/serial controller port.
// Per-master LL reservations are tracked here so store-conditional is resolved in hardware.
module mem_arbiter_llsc #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RES_LSB     = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_MASTERS*ADDR_W-1:0]       m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]       m_wdata_i,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   m_sel_n_i,
    input  logic [NUM_MASTERS-1:0]              m_en_i,
    input  logic [NUM_MASTERS-1:0]              m_wen_n_i,
    input  logic [NUM_MASTERS-1:0]              m_ll_i,
    input  logic [NUM_MASTERS-1:0]              m_sc_i,
    input  logic [NUM_MASTERS-1:0]              res_clr_i,
    output logic [DATA_W-1:0]                   m_rdata_o,
    output logic [NUM_MASTERS-1:0]              m_done_o,
    output logic [NUM_MASTERS-1:0]              m_sc_result_o,
    output logic [ADDR_W-1:0]                   s_addr_o,
    output logic [DATA_W-1:0]                   s_wdata_o,
    output logic [DATA_W/8-1:0]                 s_sel_n_o,
    output logic                                s_wen_n_o,
    output logic                                s_en_o,
    input  logic [DATA_W-1:0]                   s_rdata_i,
    input  logic                                s_done_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int GW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TAG_W = ADDR_W - RES_LSB;

    typedef enum logic [1:0] {IDLE, XFER, DONE, SCFAIL} state_e;

    state_e                   state_q;
    logic [GW-1:0]            grant_q;
    logic [GW-1:0]            last_grant_q;
    logic [ADDR_W-1:0]        s_addr_q;
    logic [DATA_W-1:0]        s_wdata_q;
    logic [SEL_W-1:0]         s_sel_n_q;
    logic                     s_wen_n_q;
    logic                     s_en_q;
    logic                     ll_q;
    logic                     sc_q;
    logic [DATA_W-1:0]        m_rdata_q;
    logic [NUM_MASTERS-1:0]   m_done_q;
    logic [NUM_MASTERS-1:0]   m_sc_result_q;
    logic [NUM_MASTERS-1:0]   res_valid_q;
    logic [NUM_MASTERS-1:0]   res_valid_d;
    logic [TAG_W-1:0]         res_tag_q [NUM_MASTERS];
    logic [TAG_W-1:0]         res_tag_d [NUM_MASTERS];

    logic                     found;
    logic [GW-1:0]            pick;
    int                       idx;
    logic [ADDR_W-1:0]        pick_addr;
    logic [TAG_W-1:0]         pick_gran;
    logic                     pick_wen_n;
    logic                     pick_ll;
    logic                     pick_sc;
    logic                     sc_ok;
    logic [NUM_MASTERS-1:0]   pick_oh;
    logic [NUM_MASTERS-1:0]   grant_oh;
    logic [TAG_W-1:0]         gran_q;

    // Search starts just after the last winner so every requester is served in turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && m_en_i[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign pick_addr  = m_addr_i[int'(pick)*ADDR_W +: ADDR_W];
    assign pick_gran  = pick_addr[ADDR_W-1:RES_LSB];
    assign pick_wen_n = m_wen_n_i[pick];
    assign pick_ll    = m_ll_i[pick] & pick_wen_n;
    assign pick_sc    = m_sc_i[pick] & ~pick_wen_n;
    assign sc_ok      = res_valid_q[pick] && (res_tag_q[pick] == pick_gran);
    assign pick_oh    = NUM_MASTERS'(1) << pick;
    assign grant_oh   = NUM_MASTERS'(1) << grant_q;
    assign gran_q     = s_addr_q[ADDR_W-1:RES_LSB];

    // A completed write kills every matching reservation, the writer's own included.
    always_comb begin
        res_valid_d = res_valid_q;
        for (int j = 0; j < NUM_MASTERS; j++) res_tag_d[j] = res_tag_q[j];
        if (state_q == XFER && s_done_i) begin
            if (ll_q) begin
                res_valid_d[grant_q] = 1'b1;
                res_tag_d[grant_q]   = gran_q;
            end
            if (!s_wen_n_q) begin
                for (int j = 0; j < NUM_MASTERS; j++) begin
                    if (res_valid_q[j] && res_tag_q[j] == gran_q) res_valid_d[j] = 1'b0;
                end
            end
        end
        res_valid_d = res_valid_d & ~res_clr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= '0;
            for (int j = 0; j < NUM_MASTERS; j++) res_tag_q[j] <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            for (int j = 0; j < NUM_MASTERS; j++) res_tag_q[j] <= res_tag_d[j];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(NUM_MASTERS - 1);
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_sel_n_q     <= '1;
            s_wen_n_q     <= 1'b1;
            s_en_q        <= 1'b0;
            ll_q          <= 1'b0;
            sc_q          <= 1'b0;
            m_rdata_q     <= '0;
            m_done_q      <= '0;
            m_sc_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        s_addr_q     <= pick_addr;
                        s_wdata_q    <= m_wdata_i[int'(pick)*DATA_W +: DATA_W];
                        s_sel_n_q    <= m_sel_n_i[int'(pick)*SEL_W +: SEL_W];
                        s_wen_n_q    <= pick_wen_n;
                        ll_q         <= pick_ll;
                        sc_q         <= pick_sc;
                        if (pick_sc && !sc_ok) begin
                            state_q  <= SCFAIL;
                            m_done_q <= pick_oh;
                        end else begin
                            state_q  <= XFER;
                            s_en_q   <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (s_done_i) begin
                        s_en_q        <= 1'b0;
                        m_rdata_q     <= s_rdata_i;
                        m_done_q      <= grant_oh;
                        m_sc_result_q <= sc_q ? grant_oh : '0;
                        state_q       <= DONE;
                    end
                end
                default: begin
                    m_done_q      <= '0;
                    m_sc_result_q <= '0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign m_rdata_o     = m_rdata_q;
    assign m_done_o      = m_done_q;
    assign m_sc_result_o = m_sc_result_q;
    assign s_addr_o      = s_addr_q;
    assign s_wdata_o     = s_wdata_q;
    assign s_sel_n_o     = s_sel_n_q;
    assign s_wen_n_o     = s_wen_n_q;
    assign s_en_o        = s_en_q;

endmodule

// File: tb/tb_mem_arbiter_llsc.sv
// Bench for mem_arbiter_llsc: plays the masters and the controller, predicting grants,
// SC outcomes and read data from a transaction-level model of the arbitration rules.
module tb_mem_arbiter_llsc;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] mAddrBus;
    logic [NM*DW-1:0] mWdataBus;
    logic [NM*SW-1:0] mSelNBus;
    logic [NM-1:0]    mEnBus, mWenNBus, mLlBus, mScBus, resClrBus;
    logic [DW-1:0]    mRdata;
    logic [NM-1:0]    mDone, mScResult;
    logic [AW-1:0]    sAddr;
    logic [DW-1:0]    sWdata;
    logic [SW-1:0]    sSelN;
    logic             sWenN, sEn;
    logic [DW-1:0]    sRdata;
    logic             sDone;

    logic [AW-1:0] mAddr  [NM];
    logic [DW-1:0] mWdata [NM];
    logic [SW-1:0] mSelN  [NM];
    logic          mEn    [NM];
    logic          mWenN  [NM];
    logic          mLl    [NM];
    logic          mSc    [NM];
    logic          resClr [NM];

    always_comb begin
        mAddrBus = '0; mWdataBus = '0; mSelNBus = '0;
        mEnBus = '0; mWenNBus = '0; mLlBus = '0; mScBus = '0; resClrBus = '0;
        for (int i = 0; i < NM; i++) begin
            mAddrBus[i*AW +: AW]  = mAddr[i];
            mWdataBus[i*DW +: DW] = mWdata[i];
            mSelNBus[i*SW +: SW]  = mSelN[i];
            mEnBus[i]    = mEn[i];
            mWenNBus[i]  = mWenN[i];
            mLlBus[i]    = mLl[i];
            mScBus[i]    = mSc[i];
            resClrBus[i] = resClr[i];
        end
    end

    mem_arbiter_llsc #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .RES_LSB(2)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .m_addr_i(mAddrBus), .m_wdata_i(mWdataBus), .m_sel_n_i(mSelNBus),
        .m_en_i(mEnBus), .m_wen_n_i(mWenNBus), .m_ll_i(mLlBus), .m_sc_i(mScBus),
        .res_clr_i(resClrBus),
        .m_rdata_o(mRdata), .m_done_o(mDone), .m_sc_result_o(mScResult),
        .s_addr_o(sAddr), .s_wdata_o(sWdata), .s_sel_n_o(sSelN), .s_wen_n_o(sWenN),
        .s_en_o(sEn), .s_rdata_i(sRdata), .s_done_i(sDone)
    );

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state: reservation per master, last winner, last returned data.
    logic          modValid [NM];
    logic [AW-3:0] modTag   [NM];
    int            modLast;
    logic [DW-1:0] modRdata;
    logic          justDone;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NM; i++) begin
            modValid[i] = 1'b0;
            modTag[i] = '0;
        end
        modLast = NM - 1;
        modRdata = '0;
        justDone = 1'b0;
    endtask

    task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic wenN, input logic ll, input logic sc);
        mEn[i] = 1'b1; mAddr[i] = a; mWdata[i] = d; mSelN[i] = '0;
        mWenN[i] = wenN; mLl[i] = ll; mSc[i] = sc;
    endtask

    task automatic randReq(input int i);
        setReq(i, 32'h8000_1000 + (($urandom % 4) << 2) + ($urandom % 4), $urandom,
               1'($urandom % 2), ($urandom % 3) == 0, ($urandom % 3) == 0);
        mSelN[i] = SW'($urandom);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
        justDone = 1'b0;
    endtask

    task automatic pulseResClr(input logic [NM-1:0] mask);
        @(negedge clk);
        for (int i = 0; i < NM; i++) resClr[i] = mask[i];
        @(negedge clk);
        for (int i = 0; i < NM; i++) begin
            resClr[i] = 1'b0;
            if (mask[i]) modValid[i] = 1'b0;
        end
        justDone = 1'b0;
    endtask

    // One arbitrated transaction; returns at the negedge where m_done is high.
    task automatic applyStimulus(input int lat, input logic [31:0] rdat,
                                 input logic [NM-1:0] clrMask, output int w);
        int cycles;
        int expWait;
        logic [AW-3:0] gran;
        logic isWr, isLl, isSc, fwd;
        logic [NM-1:0] oh;
        w = -1;
        for (int k = 1; k <= NM; k++) begin
            int j;
            j = (modLast + k) % NM;
            if (w < 0 && mEn[j]) w = j;
        end
        if (w < 0) begin
            checkOutput("noRequest", 64'd0, 64'd1);
            return;
        end
        gran = mAddr[w][AW-1:2];
        isWr = !mWenN[w];
        isLl = mLl[w] && mWenN[w];
        isSc = mSc[w] && !mWenN[w];
        fwd  = !isSc || (modValid[w] && modTag[w] == gran);
        oh = '0;
        oh[w] = 1'b1;
        expWait = justDone ? 2 : 1;
        cycles = 0;
        while (cycles < 30) begin
            @(negedge clk);
            cycles++;
            if (sEn || mDone != '0) break;
        end
        checkOutput("grantLatency", cycles, expWait);
        if (!fwd) begin
            checkOutput("scFailDone", mDone, oh);
            checkOutput("scFailResult", mScResult, '0);
            checkOutput("scFailNoSEn", sEn, 1'b0);
            checkOutput("scFailRdata", mRdata, modRdata);
        end else begin
            checkOutput("sEnSeen", sEn, 1'b1);
            checkOutput("sAddr", sAddr, mAddr[w]);
            checkOutput("sWdata", sWdata, mWdata[w]);
            checkOutput("sSelWen", {sSelN, sWenN}, {mSelN[w], mWenN[w]});
            checkOutput("noEarlyDone", mDone, '0);
            repeat (lat) begin
                @(negedge clk);
                checkOutput("sEnHold", {sEn, sAddr}, {1'b1, mAddr[w]});
            end
            sRdata = rdat;
            sDone = 1'b1;
            for (int i = 0; i < NM; i++) resClr[i] = clrMask[i];
            @(negedge clk);
            sDone = 1'b0;
            for (int i = 0; i < NM; i++) resClr[i] = 1'b0;
            checkOutput("doneMask", mDone, oh);
            checkOutput("scResult", mScResult, isSc ? oh : '0);
            checkOutput("rdata", mRdata, rdat);
            checkOutput("sEnDropped", sEn, 1'b0);
            modRdata = rdat;
            if (isLl) begin
                modValid[w] = 1'b1;
                modTag[w] = gran;
            end
            if (isWr) begin
                for (int j = 0; j < NM; j++)
                    if (modValid[j] && modTag[j] == gran) modValid[j] = 1'b0;
            end
            for (int j = 0; j < NM; j++) if (clrMask[j]) modValid[j] = 1'b0;
        end
        modLast = w;
        justDone = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int expGrant [4];
        for (int i = 0; i < NM; i++) begin
            mEn[i] = 0; mAddr[i] = '0; mWdata[i] = '0; mSelN[i] = '1;
            mWenN[i] = 1; mLl[i] = 0; mSc[i] = 0; resClr[i] = 0;
        end
        sDone = 0;
        sRdata = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rstSEn", sEn, 1'b0);
        checkOutput("rstDone", {mDone, mScResult}, '0);
        checkOutput("rstRdata", mRdata, '0);
        checkOutput("rstSAddrData", {sAddr, sWdata}, '0);
        checkOutput("rstSelWen", {sSelN, sWenN}, {{SW{1'b1}}, 1'b1});
        rstN = 1'b1;

        // Two masters requesting continuously alternate after reset.
        setReq(0, 32'h8000_0100, 32'h11, 1, 0, 0);
        setReq(1, 32'h8000_0200, 32'h22, 1, 0, 0);
        expGrant = '{0, 1, 0, 1};
        for (int t = 0; t < 4; t++) begin
            applyStimulus($urandom % 3, $urandom, '0, w);
            checkOutput("rrGrant", w, expGrant[t]);
        end
        mEn[0] = 0; mEn[1] = 0;

        idleCycles(2);
        setReq(0, 32'h8000_0010, 32'h0, 1, 0, 0);
        applyStimulus(3, 32'hDEAD_BEEF, '0, w);
        checkOutput("t1Grant", w, 0);
        mEn[0] = 0;
        @(negedge clk);
        checkOutput("t1SinglePulse", mDone, '0);
        justDone = 1'b0;

        // LL then matching SC succeeds.
        setReq(0, 32'h8000_1000, 32'h0, 1, 1, 0);
        applyStimulus(1, $urandom, '0, w);
        setReq(0, 32'h8000_1000, 32'h1, 0, 0, 1);
        applyStimulus(2, $urandom, '0, w);
        checkOutput("t3ScPass", mScResult, 3'b001);

        // Another master's write to the granule breaks the reservation.
        setReq(0, 32'h8000_1000, 32'h0, 1, 1, 0);
        applyStimulus(0, $urandom, '0, w);
        mEn[0] = 0;
        setReq(1, 32'h8000_1000, 32'h55, 0, 0, 0);
        applyStimulus(1, $urandom, '0, w);
        mEn[1] = 0;
        setReq(0, 32'h8000_1000, 32'h2, 0, 0, 1);
        applyStimulus(0, $urandom, '0, w);
        checkOutput("t4ScFail", {mDone, mScResult}, {3'b001, 3'b000});
        mEn[0] = 0;

        // Explicit clear kills the reservation; a neighbouring granule write does not.
        setReq(0, 32'h8000_1000, 32'h0, 1, 1, 0);
        applyStimulus(0, $urandom, '0, w);
        mEn[0] = 0;
        idleCycles(1);
        pulseResClr(3'b001);
        setReq(0, 32'h8000_1000, 32'h3, 0, 0, 1);
        applyStimulus(0, $urandom, '0, w);
        checkOutput("t5ClrScFail", mScResult, 3'b000);
        setReq(0, 32'h8000_1000, 32'h0, 1, 1, 0);
        applyStimulus(1, $urandom, '0, w);
        mEn[0] = 0;
        setReq(1, 32'h8000_1004, 32'h66, 0, 0, 0);
        applyStimulus(1, $urandom, '0, w);
        mEn[1] = 0;
        setReq(0, 32'h8000_1000, 32'h4, 0, 0, 1);
        applyStimulus(0, $urandom, '0, w);
        checkOutput("t5NeighbourScPass", mScResult, 3'b001);
        mEn[0] = 0;

        // Reset in the middle of a transfer.
        idleCycles(2);
        setReq(0, 32'h8000_0300, 32'h0, 1, 0, 0);
        for (int c = 0; c < 10 && !sEn; c++) @(negedge clk);
        checkOutput("t6SEnBeforeReset", sEn, 1'b1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t6ResetDrop", {sEn, mDone}, '0);
        repeat (2) @(negedge clk);
        checkOutput("t6NoDone", mDone, '0);
        rstN = 1'b1;
        modelReset();
        setReq(0, 32'h8000_0400, 32'h0, 1, 0, 0);
        setReq(1, 32'h8000_0500, 32'h0, 1, 0, 0);
        applyStimulus(1, $urandom, '0, w);
        checkOutput("t6FirstWinner", w, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < NM; i++) if ($urandom % 2 == 1) randReq(i);
        for (int t = 0; t < 250; t++) begin
            logic any;
            logic [NM-1:0] clr;
            any = 1'b0;
            for (int i = 0; i < NM; i++) any = any | mEn[i];
            if (!any) randReq($urandom % NM);
            clr = ($urandom % 4 == 0) ? NM'($urandom) : '0;
            applyStimulus($urandom % 4, $urandom, clr, w);
            if (w >= 0) begin
                if ($urandom % 4 != 0) randReq(w);
                else mEn[w] = 0;
            end
            for (int i = 0; i < NM; i++) if (i != w && !mEn[i] && $urandom % 2 == 1) randReq(i);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
